// File: rtl/prog_run_sequencer_pkg.sv
// Shared types and default constants for the program-run launch sequencer.
// The optional watchdog is enabled by defining PROG_WDOG_EN (see prog_run_sequencer.sv).
package prog_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   localparam int PC_W_DEF     = 10;
   localparam int CNT_W_DEF    = 16;
   localparam int NUM_PROG_DEF = 3;

   localparam logic [PC_W_DEF-1:0] PC_TABLE_DEF [NUM_PROG_DEF] = '{10'd0, 10'd256, 10'd512};

   // Launch rotation: 0, 1, ..., num_prog-1, 0, ...
   function automatic logic [1:0] next_prog(input logic [1:0] idx, input int num_prog);
      return (int'(idx) == num_prog - 1) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/prog_run_sequencer_if.sv
// Host handshake plus core control bundle for prog_run_sequencer.
// master = the sequencer, slave = host/core side.
interface prog_run_sequencer_if #(
   parameter int PC_W  = prog_seq_pkg::PC_W_DEF,
   parameter int CNT_W = prog_seq_pkg::CNT_W_DEF
);
   import prog_seq_pkg::*;

   // req/ack: a 0->1 edge on req requests the next program; it is accepted only
   // while no program is running. ack rises once the program finishes and stays
   // high until the next accepted req edge (or reset); req level itself is ignored.
   logic             req;
   logic             ack;
   logic             core_halt;
   logic             core_hold;
   logic             core_start;
   logic [PC_W-1:0]  core_pc_init;
   logic [1:0]       prog_idx;
   logic [CNT_W-1:0] run_cycles;
   logic             timeout;
   seq_state_t       state_dbg;

   modport master (
      input  req, core_halt,
      output ack, core_hold, core_start, core_pc_init, prog_idx, run_cycles, timeout, state_dbg
   );

   modport slave (
      output req, core_halt,
      input  ack, core_hold, core_start, core_pc_init, prog_idx, run_cycles, timeout, state_dbg
   );

endinterface

// File: rtl/prog_run_sequencer_run_cycle_counter.sv
// Saturating cycle counter with synchronous clear; sat flags the all-ones value.
module run_cycle_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   assign sat = &cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/prog_run_sequencer.sv
// Launches programs 0,1,2,... on req edges, runs the core until core_halt, then acks.
// Define PROG_WDOG_EN to add a RUN watchdog that forces DONE with timeout=1.
module prog_run_sequencer
   import prog_seq_pkg::*;
#(
   parameter int               NUM_PROG = NUM_PROG_DEF,
   parameter int               PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0]  PC_TABLE [NUM_PROG] = PC_TABLE_DEF,
   parameter int               CNT_W    = CNT_W_DEF
`ifdef PROG_WDOG_EN
   ,
   parameter logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(50000)
`endif
) (
   input logic                  clk,
   input logic                  reset,
   prog_run_sequencer_if.master bus
);

   seq_state_t       state, next_state;
   logic             req_q, go;
   logic             ack_q, hold_q, start_q;
   logic [PC_W-1:0]  pc_init_q;
   logic [1:0]       prog_idx_q;
   logic             ack_d, hold_d, start_d;
   logic [PC_W-1:0]  pc_init_d;
   logic [1:0]       prog_idx_d;
   logic             cnt_clr, run_sat, wdog_hit;
   logic [CNT_W-1:0] run_cnt;

   assign go = bus.req & ~req_q;

   // State and every output are flopped together so nothing reaches ack combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_q      <= 1'b0;
         ack_q      <= 1'b0;
         hold_q     <= 1'b1;
         start_q    <= 1'b0;
         pc_init_q  <= PC_TABLE[0];
         prog_idx_q <= 2'd0;
      end else begin
         state      <= next_state;
         req_q      <= bus.req;
         ack_q      <= ack_d;
         hold_q     <= hold_d;
         start_q    <= start_d;
         pc_init_q  <= pc_init_d;
         prog_idx_q <= prog_idx_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (go) next_state = LAUNCH;
         LAUNCH:  next_state = RUN;
         RUN:     if (bus.core_halt || wdog_hit) next_state = DONE;
         DONE:    if (go) next_state = LAUNCH;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      start_d    = (next_state == LAUNCH);
      hold_d     = !((next_state == LAUNCH) || (next_state == RUN));
      ack_d      = (next_state == DONE);
      pc_init_d  = pc_init_q;
      prog_idx_d = prog_idx_q;
      if (next_state == LAUNCH) begin
         pc_init_d = PC_TABLE[prog_idx_q];
      end
      if ((state == RUN) && (next_state == DONE)) begin
         prog_idx_d = next_prog(prog_idx_q, NUM_PROG);
      end
   end

   // Counter reads 0 throughout LAUNCH and counts each RUN cycle, including the halt cycle.
   assign cnt_clr = (next_state == LAUNCH);

   run_cycle_counter #(.CNT_W(CNT_W)) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    ((state == RUN) && !run_sat),
      .cnt   (run_cnt),
      .sat   (run_sat)
   );

`ifdef PROG_WDOG_EN
   logic [CNT_W-1:0] wdog_cnt;
   logic             wdog_sat;
   logic             timeout_q;

   run_cycle_counter #(.CNT_W(CNT_W)) u_wdog_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    ((state == RUN) && !wdog_sat),
      .cnt   (wdog_cnt),
      .sat   (wdog_sat)
   );

   // Fires in the WDOG_LIMIT-th RUN cycle; a halt in that same cycle takes precedence.
   assign wdog_hit = (state == RUN) && (wdog_cnt == WDOG_LIMIT - 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else if (next_state == LAUNCH) begin
         timeout_q <= 1'b0;
      end else if (wdog_hit && !bus.core_halt) begin
         timeout_q <= 1'b1;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign wdog_hit    = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign bus.ack          = ack_q;
   assign bus.core_hold    = hold_q;
   assign bus.core_start   = start_q;
   assign bus.core_pc_init = pc_init_q;
   assign bus.prog_idx     = prog_idx_q;
   assign bus.run_cycles   = run_cnt;
   assign bus.state_dbg    = state;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Scoreboard bench for prog_run_sequencer: driver pushes expected launch/finish events,
// a negedge monitor pops and compares them when core_start pulses or ack rises.
module tb_prog_run_sequencer;
   import prog_seq_pkg::*;

   localparam int PC_W     = 10;
   localparam int CNT_W    = 16;
   localparam int NUM_PROG = 3;
   localparam int EW       = 1 + PC_W + 2 + CNT_W + 1;
   localparam int CYC_L    = 1;
   localparam int IDX_L    = CNT_W + 1;
   localparam int PC_L     = CNT_W + 3;
   localparam int KIND_B   = EW - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   prog_run_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   prog_run_sequencer #(
      .NUM_PROG (NUM_PROG),
      .PC_W     (PC_W),
      .CNT_W    (CNT_W)
`ifdef PROG_WDOG_EN
      ,
      .WDOG_LIMIT (16'd100)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [EW-1:0] exp_q[$];

   // Reference model: which program is next in the rotation and where each one starts.
   int ref_prog = 0;
   int ref_pc [NUM_PROG] = '{0, 256, 512};

   function automatic logic [EW-1:0] pack(input bit kind, input int pc, input int idx,
                                          input int cyc, input bit to);
      return {kind, PC_W'(pc), 2'(idx), CNT_W'(cyc), to};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic ack_prev = 1'b0;
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (reset) begin
         ack_prev = 1'b0;
      end else begin
         if (bus.core_start === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL start_unexpected: got core_start=1 with no launch expected");
            end else begin
               e = exp_q.pop_front();
               check("start_kind", 32'(bus.core_start & ~e[KIND_B]), 32'd1);
               check("start_pc_init", 32'(bus.core_pc_init), 32'(e[PC_L +: PC_W]));
               check("start_prog_idx", 32'(bus.prog_idx), 32'(e[IDX_L +: 2]));
               check("start_ack_low", 32'(bus.ack), 32'd0);
               check("start_hold_low", 32'(bus.core_hold), 32'd0);
               check("start_run_cycles", 32'(bus.run_cycles), 32'd0);
               check("start_timeout", 32'(bus.timeout), 32'(e[0]));
            end
         end
         if (bus.ack === 1'b1 && ack_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ack_unexpected: got ack rise with no finish expected");
            end else begin
               e = exp_q.pop_front();
               check("ack_kind", 32'(e[KIND_B]), 32'd1);
               check("ack_run_cycles", 32'(bus.run_cycles), 32'(e[CYC_L +: CNT_W]));
               check("ack_prog_idx", 32'(bus.prog_idx), 32'(e[IDX_L +: 2]));
               check("ack_timeout", 32'(bus.timeout), 32'(e[0]));
               check("ack_hold_high", 32'(bus.core_hold), 32'd1);
            end
         end
         ack_prev = bus.ack;
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge of the core_start cycle.
   task automatic launch();
      exp_q.push_back(pack(1'b0, ref_pc[ref_prog], ref_prog, 0, 1'b0));
      bus.req = 1'b1;
      @(posedge clk); #1;
      check("launch_latency", 32'(bus.core_start), 32'd1);
      @(negedge clk);
      bus.req = 1'b0;
   endtask

   task automatic expect_finish(input int cyc, input bit to);
      int nxt;
      nxt = (ref_prog + 1) % NUM_PROG;
      exp_q.push_back(pack(1'b1, ref_pc[ref_prog], nxt, cyc, to));
      ref_prog = nxt;
   endtask

   // mode 0: clean run; mode 1: stray req edge during RUN; mode 2: req edge with halt.
   task automatic run_prog(input int d, input int mode);
      int k;
      k = (mode == 0) ? 0 : ((mode == 2) ? d : int'($urandom_range(1, d)));
      launch();
      for (int i = 1; i <= d; i++) begin
         @(negedge clk);
         bus.req = (k == i);
         if (i < d) check("no_early_ack", 32'(bus.ack), 32'd0);
      end
      bus.core_halt = 1'b1;
      expect_finish(d, 1'b0);
      @(negedge clk);
      bus.core_halt = 1'b0;
      bus.req = 1'b0;
      check("ack_latency", 32'(bus.ack), 32'd1);
      repeat ($urandom_range(1, 4)) begin
         @(negedge clk);
         check("ack_hold", 32'(bus.ack), 32'd1);
         check("run_cycles_frozen", 32'(bus.run_cycles), 32'(d));
         check("hold_in_done", 32'(bus.core_hold), 32'd1);
      end
   endtask

   task automatic wait_ack(input int budget, output int n);
      n = 0;
      while (bus.ack !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("ack_within_budget", 32'(bus.ack), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      bus.req = 1'b0;
      bus.core_halt = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state and idle: no launch, halt ignored.
      check("rst_pc_init", 32'(bus.core_pc_init), 32'd0);
      check("rst_run_cycles", 32'(bus.run_cycles), 32'd0);
      check("rst_timeout", 32'(bus.timeout), 32'd0);
      for (int i = 0; i < 5; i++) begin
         bus.core_halt = (i == 2);
         @(negedge clk);
         check("idle_ack", 32'(bus.ack), 32'd0);
         check("idle_hold", 32'(bus.core_hold), 32'd1);
         check("idle_prog_idx", 32'(bus.prog_idx), 32'd0);
         check("idle_start", 32'(bus.core_start), 32'd0);
      end
      bus.core_halt = 1'b0;

      // First program, 20 run cycles; then programs 1 and 2.
      run_prog(20, 0);
      run_prog(5, 0);
      run_prog(7, 0);

      // Held req: a single launch, ack held through the remaining high level.
      exp_q.push_back(pack(1'b0, ref_pc[ref_prog], ref_prog, 0, 1'b0));
      bus.req = 1'b1;
      @(posedge clk); #1;
      check("held_latency", 32'(bus.core_start), 32'd1);
      @(negedge clk);
      for (int i = 1; i <= 29; i++) begin
         @(negedge clk);
         bus.core_halt = (i == 10);
         if (i == 10) expect_finish(10, 1'b0);
         if (i > 11) check("held_ack", 32'(bus.ack), 32'd1);
      end
      bus.req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("held_ack_after", 32'(bus.ack), 32'd1);
      end

      // Randomised runs with dropped and colliding req edges.
      for (int it = 0; it < 10; it++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_prog(int'($urandom_range(1, 40)), int'($urandom_range(0, 2)));
      end

      // Halt stuck high across DONE -> LAUNCH: RUN lasts one cycle.
      bus.core_halt = 1'b1;
      @(negedge clk);
      launch();
      expect_finish(1, 1'b0);
      repeat (2) @(negedge clk);
      check("stuck_halt_ack", 32'(bus.ack), 32'd1);
      bus.core_halt = 1'b0;
      @(negedge clk);

      // Reset mid-RUN, then program 0 relaunches.
      if (ref_prog == 0) run_prog(3, 0);
      launch();
      repeat (8) @(negedge clk);
      check("mid_run_cycles", 32'(bus.run_cycles), 32'd7);
      reset = 1'b1;
      #1;
      check("arst_ack", 32'(bus.ack), 32'd0);
      check("arst_hold", 32'(bus.core_hold), 32'd1);
      check("arst_start", 32'(bus.core_start), 32'd0);
      check("arst_prog_idx", 32'(bus.prog_idx), 32'd0);
      check("arst_pc_init", 32'(bus.core_pc_init), 32'd0);
      check("arst_run_cycles", 32'(bus.run_cycles), 32'd0);
      check("arst_timeout", 32'(bus.timeout), 32'd0);
      ref_prog = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_prog(6, 0);

`ifdef PROG_WDOG_EN
      // No halt: watchdog ends the run after 100 RUN cycles; next launch clears timeout.
      launch();
      expect_finish(100, 1'b1);
      wait_ack(300, n);
      check("wdog_latency", 32'(n), 32'd101);
      check("wdog_timeout_set", 32'(bus.timeout), 32'd1);
      @(negedge clk);
      run_prog(4, 0);
`else
      // No watchdog: a long run keeps going until halt.
      run_prog(200, 0);
      n = 0;
`endif

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
